avalon_ddr3_responder: RTL and testbench
========================================

Name: avalon_ddr3_responder

Overview:
- Avalon-MM slave that answers the DDR3 master side of the canny datapath: single-port 128-bit on-chip memory with byteenable writes, bursts, a programmable read latency and injectable waitrequest stalls.
- Replaces the HPS/DDR3 bridge in simulation and serves as an on-chip staging buffer in hardware.
- Lets master-side blocks be exercised against realistic waitrequest/readdatavalid timing.

Parameters:
- DATA_W, 128, data bus width in bits; byteenable width is DATA_W/8.
- ADDR_W, 32, byte address width.
- BURST_W, 7, burstcount width.
- DEPTH_WORDS, 1024, memory depth in DATA_W words (power of two).
- READ_LATENCY, 2, cycles from read-beat issue to readdatavalid (>=1).
- WAIT_CYCLES, 0, cycles waitrequest is held high on a pending command before acceptance.

Ports:
- main_clk  in  1  sole clock.
- main_reset  in  1  synchronous, active-high reset.
- avs_s0_read  in  1  read command.
- avs_s0_write  in  1  write command / write beat.
- avs_s0_address  in  ADDR_W  byte address.
- avs_s0_writedata  in  DATA_W  write data.
- avs_s0_byteenable  in  DATA_W/8  per-byte write mask.
- avs_s0_burstcount  in  BURST_W  beats in burst.
- avs_s0_readdata  out  DATA_W  read data.
- avs_s0_readdatavalid  out  1  readdata valid.
- avs_s0_waitrequest  out  1  stall.
- protocol_err  out  1  sticky protocol-violation flag.
- rd_beat_count  out  32  read beats returned (wraps).
- wr_beat_count  out  32  write beats committed (wraps).

Behaviour:
- Reset values:
  - state IDLE, readdata 0, readdatavalid 0, protocol_err 0, both counters 0.
  - Read pipeline flushed.
  - waitrequest forced 1 while main_reset is high.
  - Memory contents are not cleared by reset.
- Word index = address[4 +: log2(DEPTH_WORDS)]; address[3:0] ignored. Burst beat k uses (index+k) mod DEPTH_WORDS, so bursts wrap.
- burstcount 0 is treated as 1 and sets protocol_err.
- IDLE:
  - stall_cnt increments each cycle read|write is high while stall_cnt < WAIT_CYCLES.
  - waitrequest = (stall_cnt < WAIT_CYCLES), so with WAIT_CYCLES=0 it stays 0 in IDLE.
  - A command is accepted when (read|write) && !waitrequest; stall_cnt clears on acceptance.
  - If read and write are both high, write wins and protocol_err is set.
- Write accept:
  - Beat 0 is committed in the acceptance cycle; bytes with byteenable=0 are untouched; wr_beat_count is incremented.
  - Latch base index and remaining = burstcount-1; if remaining>0 go to WR_BURST, else stay in IDLE.
- WR_BURST:
  - waitrequest=0.
  - Each cycle with write=1 commits the next beat at base+beat index; a cycle with write=0 makes no progress.
  - The last beat returns the block to IDLE.
  - read=1 in this state sets protocol_err and is otherwise ignored.
- Read accept:
  - Beat 0 is issued in the acceptance cycle.
  - If burstcount>1, go to RD_BURST, where waitrequest=1 and one beat issues per cycle until the last beat, then return to IDLE.
- Read timing:
  - For a read accepted at cycle T, beat k appears with readdatavalid=1 at T+READ_LATENCY+k.
  - Beats are contiguous, in order, and rd_beat_count increments per beat.
- Memory is sampled at issue, so a write accepted after the last issue does not affect in-flight beats.
- A new command may be accepted while earlier read beats are still in the pipeline; order is preserved.
- Reset mid-burst: state returns to IDLE, in-flight readdatavalid beats are dropped, and partial write beats already committed remain in memory.

Decomposition:
- Package avalon_ddr3_pkg holds:
  - DATA_W, ADDR_W, BURST_W and BE_W constants.
  - responder_state_t enum {IDLE, WR_BURST, RD_BURST}.
- Sub-module be_sp_ram: single-port DATA_W x DEPTH_WORDS RAM with byte-enable write and a registered read port.
- The remaining READ_LATENCY-1 stages are a valid/data shift register in the top module.

Test Plan:
- Single write then read, WAIT_CYCLES=0, READ_LATENCY=2: write 0x...A5 at 0x40 with byteenable 0xFFFF, then read 0x40 accepted at T -> readdatavalid at T+2 with 0x...A5; wr_beat_count=1, rd_beat_count=1.
- Byteenable: write all-ones at 0x80, then all-zeros with byteenable 0x00FF -> read returns upper 64 bits 1s, lower 64 bits 0s.
- Burst with gaps: 4-beat write at 0x100 with write deasserted for 2 cycles after beat 1, then 4-beat read -> 4 contiguous valid beats in order matching the written data; waitrequest high for 3 cycles after read accept.
- Stall: WAIT_CYCLES=3, read held high -> waitrequest high 3 cycles, accepted on the 4th; data valid READ_LATENCY cycles later.
- Wrap and error: DEPTH_WORDS=1024, 2-beat write at byte address 0x3FF0 -> second beat lands at word 0; burstcount=0 read -> one beat returned and protocol_err=1 until reset.
- Reset mid-read: assert main_reset while beat 1 of a 4-beat read is in the pipeline -> no further readdatavalid, waitrequest=1 during reset, state IDLE and accepting commands after reset deasserts.

Source files
------------

// File: rtl/avalon_ddr3_pkg.sv
// Shared constants and state type for the Avalon DDR3 responder.
// Bus widths match the canny datapath DDR3 master port.
package avalon_ddr3_pkg;

    localparam int DATA_W  = 128;
    localparam int ADDR_W  = 32;
    localparam int BURST_W = 7;
    localparam int BE_W    = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } responder_state_t;

endpackage

// File: rtl/be_sp_ram.sv
// Single-port word RAM with per-byte write enables.
// The read port is registered and reads the old word on a same-cycle write.
module be_sp_ram #(
    parameter int DATA_W      = 128,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [DATA_W/8-1:0]            be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              q
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/avalon_ddr3_responder.sv
// Avalon-MM slave emulating the DDR3 bridge: bursts, byteenable writes,
// programmable read latency and injected waitrequest stalls.
module avalon_ddr3_responder #(
    parameter int DATA_W       = avalon_ddr3_pkg::DATA_W,
    parameter int ADDR_W       = avalon_ddr3_pkg::ADDR_W,
    parameter int BURST_W      = avalon_ddr3_pkg::BURST_W,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                main_clk,
    input  logic                main_reset,
    input  logic                avs_s0_read,
    input  logic                avs_s0_write,
    input  logic [ADDR_W-1:0]   avs_s0_address,
    input  logic [DATA_W-1:0]   avs_s0_writedata,
    input  logic [DATA_W/8-1:0] avs_s0_byteenable,
    input  logic [BURST_W-1:0]  avs_s0_burstcount,
    output logic [DATA_W-1:0]   avs_s0_readdata,
    output logic                avs_s0_readdatavalid,
    output logic                avs_s0_waitrequest,
    output logic                protocol_err,
    output logic [31:0]         rd_beat_count,
    output logic [31:0]         wr_beat_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int SC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    import avalon_ddr3_pkg::*;

    responder_state_t        state;
    logic [IDX_W-1:0]        base_idx;
    logic [BURST_W-1:0]      beat;
    logic [BURST_W-1:0]      remaining;
    logic [SC_W-1:0]         stall_cnt;
    logic [IDX_W-1:0]        cmd_idx;
    logic [IDX_W-1:0]        ram_addr;
    logic [BURST_W-1:0]      bc_eff;
    logic                    stalled;
    logic                    cmd;
    logic                    accept;
    logic                    ram_we;
    logic                    issue;
    logic [DATA_W-1:0]       ram_q;
    logic [READ_LATENCY-1:0] vld;
    logic                    unused_addr;

    assign cmd_idx     = avs_s0_address[4 +: IDX_W];
    assign unused_addr = ^{avs_s0_address[3:0],
                           avs_s0_address[ADDR_W-1:4+IDX_W]};
    assign bc_eff      = (avs_s0_burstcount == '0) ? BURST_W'(1)
                                                   : avs_s0_burstcount;
    // stall_cnt saturates at WAIT_CYCLES, so equality marks the end of the stall
    assign stalled = (stall_cnt != SC_W'(WAIT_CYCLES));
    assign cmd     = avs_s0_read | avs_s0_write;
    assign accept  = (state == IDLE) && cmd && !stalled && !main_reset;

    assign avs_s0_waitrequest = main_reset
                              | (state == RD_BURST)
                              | ((state == IDLE) && stalled);

    always_comb begin
        ram_we   = 1'b0;
        issue    = 1'b0;
        ram_addr = cmd_idx;
        if (!main_reset) begin
            case (state)
                IDLE: begin
                    ram_we = accept && avs_s0_write;
                    issue  = accept && !avs_s0_write;
                end
                WR_BURST: begin
                    ram_addr = base_idx + IDX_W'(beat);
                    ram_we   = avs_s0_write;
                end
                RD_BURST: begin
                    ram_addr = base_idx + IDX_W'(beat);
                    issue    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge main_clk) begin
        if (main_reset) begin
            state         <= IDLE;
            base_idx      <= '0;
            beat          <= '0;
            remaining     <= '0;
            stall_cnt     <= '0;
            protocol_err  <= 1'b0;
            wr_beat_count <= '0;
        end else begin
            if (ram_we) begin
                wr_beat_count <= wr_beat_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        stall_cnt <= '0;
                        base_idx  <= cmd_idx;
                        beat      <= BURST_W'(1);
                        remaining <= bc_eff - BURST_W'(1);
                        if (bc_eff != BURST_W'(1)) begin
                            state <= avs_s0_write ? WR_BURST : RD_BURST;
                        end
                        if ((avs_s0_read && avs_s0_write)
                            || (avs_s0_burstcount == '0)) begin
                            protocol_err <= 1'b1;
                        end
                    end else if (cmd && stalled) begin
                        stall_cnt <= stall_cnt + SC_W'(1);
                    end
                end
                WR_BURST: begin
                    if (avs_s0_read) begin
                        protocol_err <= 1'b1;
                    end
                    if (avs_s0_write) begin
                        beat      <= beat + BURST_W'(1);
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    beat      <= beat + BURST_W'(1);
                    remaining <= remaining - BURST_W'(1);
                    if (remaining == BURST_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    be_sp_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (main_clk),
        .rst   (main_reset),
        .we    (ram_we),
        .be    (avs_s0_byteenable),
        .addr  (ram_addr),
        .wdata (avs_s0_writedata),
        .q     (ram_q)
    );

    // RAM output register is the first latency stage
    always_ff @(posedge main_clk) begin
        if (main_reset) begin
            vld           <= '0;
            rd_beat_count <= '0;
        end else begin
            vld[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
            if (vld[READ_LATENCY-1]) begin
                rd_beat_count <= rd_beat_count + 32'd1;
            end
        end
    end

    assign avs_s0_readdatavalid = vld[READ_LATENCY-1];

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign avs_s0_readdata = ram_q;
        end else begin : g_latn
            logic [DATA_W-1:0] dly [READ_LATENCY-1];
            always_ff @(posedge main_clk) begin
                if (main_reset) begin
                    for (int i = 0; i < READ_LATENCY - 1; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= ram_q;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end
            assign avs_s0_readdata = dly[READ_LATENCY-2];
        end
    endgenerate

endmodule

// File: tb/tb_avalon_ddr3_responder.sv
// Scoreboard bench for avalon_ddr3_responder: a zero-stall instance for
// data/burst/reset behaviour and a WAIT_CYCLES=3 instance for stalls.
module tb_avalon_ddr3_responder;

    typedef struct {
        logic [127:0] data;
        int unsigned  cyc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int unsigned  cyc = 0;

    logic         rd = 1'b0, wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [15:0]  be = '0;
    logic [6:0]   bc = 7'd1;
    logic [127:0] rdata;
    logic         rvalid, wait_req, perr;
    logic [31:0]  rcnt, wcnt;

    logic         s_rd = 1'b0, s_wr = 1'b0;
    logic [31:0]  s_addr = '0;
    logic [127:0] s_wdata = '0;
    logic [15:0]  s_be = '0;
    logic [6:0]   s_bc = 7'd1;
    logic [127:0] s_rdata;
    logic         s_rvalid, s_wait, s_perr;
    logic [31:0]  s_rcnt, s_wcnt;

    int           n_chk = 0;
    int           n_fail = 0;
    int unsigned  exp_rd = 0;
    int unsigned  exp_wr = 0;
    sb_t          sb[$];
    sb_t          mon_e;
    logic [127:0] model [1024];
    logic [127:0] wbuf [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_ddr3_responder #(
        .DEPTH_WORDS (1024),
        .READ_LATENCY(2),
        .WAIT_CYCLES (0)
    ) dut (
        .main_clk            (clk),
        .main_reset          (rst),
        .avs_s0_read         (rd),
        .avs_s0_write        (wr),
        .avs_s0_address      (addr),
        .avs_s0_writedata    (wdata),
        .avs_s0_byteenable   (be),
        .avs_s0_burstcount   (bc),
        .avs_s0_readdata     (rdata),
        .avs_s0_readdatavalid(rvalid),
        .avs_s0_waitrequest  (wait_req),
        .protocol_err        (perr),
        .rd_beat_count       (rcnt),
        .wr_beat_count       (wcnt)
    );

    avalon_ddr3_responder #(
        .DEPTH_WORDS (1024),
        .READ_LATENCY(2),
        .WAIT_CYCLES (3)
    ) dut_s (
        .main_clk            (clk),
        .main_reset          (rst),
        .avs_s0_read         (s_rd),
        .avs_s0_write        (s_wr),
        .avs_s0_address      (s_addr),
        .avs_s0_writedata    (s_wdata),
        .avs_s0_byteenable   (s_be),
        .avs_s0_burstcount   (s_bc),
        .avs_s0_readdata     (s_rdata),
        .avs_s0_readdatavalid(s_rvalid),
        .avs_s0_waitrequest  (s_wait),
        .protocol_err        (s_perr),
        .rd_beat_count       (s_rcnt),
        .wr_beat_count       (s_wcnt)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 128'(rvalid), 128'(0));
            end else begin
                mon_e = sb.pop_front();
                check("rdata", rdata, mon_e.data);
                check("rd_cycle", 128'(cyc), 128'(mon_e.cyc));
                exp_rd++;
            end
        end
    end

    task automatic wait_accept(output int unsigned c);
        int n;
        n = 0;
        @(negedge clk);
        while (wait_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", 128'(wait_req), 128'(0));
        c = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input int n_bc,
                            input logic [15:0] m, input int gap);
        int          beats;
        int unsigned c;
        logic [9:0]  idx;
        beats = (n_bc == 0) ? 1 : n_bc;
        for (int k = 0; k < beats; k++) begin
            if (k == 2 && gap > 0) begin
                wr = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            wr    = 1'b1;
            addr  = a;
            bc    = 7'(n_bc);
            wdata = wbuf[k];
            be    = m;
            wait_accept(c);
            idx = a[13:4] + 10'(k);
            for (int b = 0; b < 16; b++) begin
                if (m[b]) model[idx][8*b +: 8] = wbuf[k][8*b +: 8];
            end
            exp_wr++;
        end
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int n_bc);
        int          beats;
        int unsigned c;
        logic [9:0]  idx;
        beats = (n_bc == 0) ? 1 : n_bc;
        rd   = 1'b1;
        addr = a;
        bc   = 7'(n_bc);
        wait_accept(c);
        rd = 1'b0;
        for (int k = 0; k < beats; k++) begin
            idx = a[13:4] + 10'(k);
            sb.push_back('{data: model[idx], cyc: c + 2 + k});
        end
        for (int k = 1; k < beats; k++) begin
            @(negedge clk);
            check("rd_burst_wait", 128'(wait_req), 128'(1));
        end
        @(negedge clk);
        check("rd_idle_wait", 128'(wait_req), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain", 128'(sb.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned c;
        int          n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 128'(rvalid), 128'(0));
        check("rst_perr", 128'(perr), 128'(0));
        check("rst_rcnt", 128'(rcnt), 128'(0));
        check("rst_wcnt", 128'(wcnt), 128'(0));
        check("rst_wait", 128'(wait_req), 128'(1));
        check("rst_wait_s", 128'(s_wait), 128'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        wbuf[0] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_32a5;
        do_write(32'h40, 1, 16'hffff, 0);
        do_read(32'h40, 1);
        drain();
        check("wcnt_single", 128'(wcnt), 128'(1));
        check("rcnt_single", 128'(rcnt), 128'(1));

        wbuf[0] = '1;
        do_write(32'h80, 1, 16'hffff, 0);
        wbuf[0] = '0;
        do_write(32'h80, 1, 16'h00ff, 0);
        check("be_model", model[8], {64'hffff_ffff_ffff_ffff, 64'h0});
        do_read(32'h80, 1);
        drain();

        for (int k = 0; k < 4; k++) begin
            wbuf[k] = {4{32'hc0de_0000 + 32'(k)}};
        end
        do_write(32'h100, 4, 16'hffff, 2);
        do_read(32'h100, 4);
        drain();

        wbuf[0] = {4{32'h1111_3ff0}};
        wbuf[1] = {4{32'h2222_0000}};
        do_write(32'h3ff0, 2, 16'hffff, 0);
        do_read(32'h0, 1);
        do_read(32'h3ff0, 2);
        drain();
        check("wcnt_mid", 128'(wcnt), 128'(exp_wr));
        check("rcnt_mid", 128'(rcnt), 128'(exp_rd));

        check("perr_clean", 128'(perr), 128'(0));
        do_read(32'h40, 0);
        drain();
        check("perr_bc0", 128'(perr), 128'(1));
        do_read(32'h80, 1);
        drain();
        check("perr_sticky", 128'(perr), 128'(1));
        check("rcnt_bc0", 128'(rcnt), 128'(exp_rd));

        rd   = 1'b1;
        addr = 32'h100;
        bc   = 7'd4;
        wait_accept(c);
        rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{data: model[16+k], cyc: c + 2 + k});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        exp_rd = 0;
        exp_wr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstmid_valid", 128'(rvalid), 128'(0));
            check("rstmid_wait", 128'(wait_req), 128'(1));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_valid", 128'(rvalid), 128'(0));
        end
        check("post_rst_perr", 128'(perr), 128'(0));
        check("post_rst_rcnt", 128'(rcnt), 128'(0));
        check("post_rst_wait", 128'(wait_req), 128'(0));
        @(posedge clk);
        #1;
        do_read(32'h80, 1);
        drain();
        check("post_rst_rcnt1", 128'(rcnt), 128'(1));

        s_wr    = 1'b1;
        s_addr  = 32'h200;
        s_wdata = 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0;
        s_be    = 16'hffff;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_wr_wait", 128'(s_wait), 128'(i < 3));
        end
        @(posedge clk);
        #1 s_wr = 1'b0;
        s_rd = 1'b1;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_rd_wait", 128'(s_wait), 128'(i < 3));
            c = cyc;
        end
        @(posedge clk);
        #1 s_rd = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_rvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("stall_rvalid", 128'(s_rvalid), 128'(1));
        check("stall_rd_cycle", 128'(cyc), 128'(c + 2));
        check("stall_rdata", s_rdata, 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0);
        check("stall_wcnt", 128'(s_wcnt), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
